frame_writer: RTL
=================

Name: frame_writer

Overview:
- Upstream feeder for the 8-byte flight-parameter register RAM.
- Parses a byte stream from the serial receiver (one byte per rx_valid strobe) into framed write commands.
- Buffers the payload and verifies the checksum. Only then does it commit the bytes to the RAM write port, one byte per cycle.
- A corrupt or truncated frame never modifies RAM contents.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 8, payload capacity in bytes; equals the RAM depth.
- TIMEOUT_CYCLES, 50000, maximum idle clock cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk_system  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid on that cycle.
- wr  out  1  RAM write enable.
- wr_addr  out  8  RAM write address.
- wr_data  out  8  RAM write data.
- busy  out  1  high while in state COMMIT; rx bytes are dropped.
- frame_ok  out  1  one-cycle pulse when a frame has been fully committed.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- err_count  out  8  count of rejected frames, saturating at 8'hFF.

Behaviour:
- Reset: while reset is high at a clock edge, the following are cleared to 0: wr, wr_addr, wr_data, busy, frame_ok, frame_err, err_count, and the payload buffer. State goes to IDLE.
- Reset arriving mid-COMMIT truncates the commit. Any writes already issued stay issued, and there is no frame_ok.
- Frame format: SYNC_BYTE, ADDR, LEN, DATA[0..LEN-1], CHK.
- Checksum rule: CHK == (ADDR + LEN + sum of DATA) mod 256, computed with an 8-bit wrapping accumulator.
- FSM states: IDLE, ADDR, LEN, DATA, CHK, COMMIT. All transitions below occur on an rx_valid cycle unless noted.
  - IDLE: rx_data == SYNC_BYTE -> ADDR. Any other byte is ignored; no error is raised.
  - ADDR: latch addr, set sum = byte -> LEN.
  - LEN: LEN == 0, LEN > MAX_LEN, or ADDR + LEN > MAX_LEN (computed 9 bits wide) -> error, go to IDLE. Otherwise latch len, add LEN to sum, clear index -> DATA.
  - DATA: buffer[index] = byte, add byte to sum, index++. When index reaches len -> CHK.
  - CHK: byte == sum -> COMMIT. Mismatch -> error, go to IDLE.
  - COMMIT (advances every cycle, independent of rx_valid): for i = 0..len-1, drive wr=1, wr_addr=addr+i, wr_data=buffer[i] on consecutive cycles. The cycle after the last write: wr=0, frame_ok=1 for one cycle, return to IDLE.
- Latency: the CHK byte is sampled at edge N. First write is visible at edge N+1, last at edge N+len. frame_ok is high in the cycle following edge N+len+1.
- busy is high for exactly len cycles. rx_valid during COMMIT is dropped entirely, including a SYNC_BYTE.
- A SYNC_BYTE received in states ADDR through CHK is treated as ordinary data. There is no resynchronisation mid-frame.
- Timeout: the counter is cleared on every rx_valid and while in IDLE or COMMIT, and increments otherwise. On reaching TIMEOUT_CYCLES -> error, go to IDLE.
- Error action: frame_err=1 for one cycle, err_count++ (saturating), no RAM writes issued.
- Outside COMMIT, wr=0; wr_addr and wr_data hold their last value.
- If a byte arrives on the same edge that the timeout fires, the timeout wins and the byte is discarded.

Test Plan:
- Nominal write: bytes A5 02 03 11 22 33 6B -> wr high for 3 consecutive cycles with (addr,data) = (02,11), (03,22), (04,33); frame_ok pulses once; err_count stays 0.
- Bad checksum: A5 00 01 55 57 (correct CHK is 56) -> no wr; frame_err pulses one cycle; err_count = 1.
- Range and length errors: A5 06 03 … -> frame_err at the LEN byte. A5 00 00 -> frame_err. A5 00 09 -> frame_err. In all cases no wr, and err_count increments for each.
- Timeout: A5 01, then no rx_valid for 50000 cycles -> frame_err exactly at TIMEOUT_CYCLES. A following valid frame A5 00 01 AA AB is then accepted and writes addr 0 = AA.
- Busy drop and noise: send a full 8-byte frame to addr 0 and assert rx_valid with A5 during COMMIT -> that byte is dropped. Leading noise 00 FF before A5 is ignored. All 8 bytes are written and frame_ok pulses.
- Reset mid-commit: assert reset on the 2nd write cycle of a 4-byte commit -> the following edge shows wr=0, busy=0, err_count=0, no frame_ok, state IDLE.

Source files
------------

// File: rtl/frame_writer.sv
// frame_writer: parses a serial byte stream into framed RAM write commands.
// Frame layout: SYNC_BYTE, ADDR, LEN, DATA[0..LEN-1], CHK where
// CHK = (ADDR + LEN + sum(DATA)) mod 256. The payload is buffered and only
// committed to the RAM write port once the checksum has matched, so a corrupt,
// out-of-range or truncated frame never touches RAM.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure. While busy is high (commit in progress) strobes are dropped.
//
// state_dbg encoding: 0 IDLE, 1 ADDR, 2 LEN, 3 DATA, 4 CHK, 5 COMMIT.
module frame_writer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_system,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic [2:0] state_dbg
);

  // Counter wide enough to hold 0..MAX_LEN; buffer address wide enough for 0..MAX_LEN-1.
  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LEN    = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]       addr_q;
  logic [CNT_W-1:0] len_q;
  logic [7:0]       sum_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] cmt_idx_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       buffer [MAX_LEN];

  logic in_frame;
  logic tmo_fire;
  logic take;
  logic len_bad;
  logic [8:0] end_addr;
  logic do_err;
  logic do_ok;
  logic do_write;

  assign state_dbg = state;

  // A frame is "open" between the sync byte and the checksum byte.
  assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                    (state == S_DATA) || (state == S_CHK);

  // Timeout fires on the edge the idle counter would reach TIMEOUT_CYCLES;
  // it takes priority over a byte arriving on that same edge.
  assign tmo_fire = in_frame && (tmo_cnt == TMO_LAST);
  assign take     = rx_valid && !tmo_fire;

  // Length checks done 9 bits wide so ADDR + LEN cannot wrap past the RAM end.
  assign end_addr = {1'b0, addr_q} + {1'b0, rx_data};
  assign len_bad  = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN)) ||
                    (end_addr > 9'(MAX_LEN));

  // State register.
  always_ff @(posedge clk_system) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus the error / completion / write strobes.
  always_comb begin
    state_next = state;
    do_err     = 1'b0;
    do_ok      = 1'b0;
    do_write   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (tmo_fire) begin
          do_err     = 1'b1;
          state_next = S_IDLE;
        end else if (take) begin
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (tmo_fire) begin
          do_err     = 1'b1;
          state_next = S_IDLE;
        end else if (take) begin
          if (len_bad) begin
            do_err     = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tmo_fire) begin
          do_err     = 1'b1;
          state_next = S_IDLE;
        end else if (take && ((idx_q + CNT_ONE) == len_q)) begin
          state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (tmo_fire) begin
          do_err     = 1'b1;
          state_next = S_IDLE;
        end else if (take) begin
          if (rx_data == sum_q) begin
            state_next = S_COMMIT;
          end else begin
            do_err     = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        // Runs every cycle; rx strobes are ignored here.
        if (cmt_idx_q == len_q) begin
          do_ok      = 1'b1;
          state_next = S_IDLE;
        end else begin
          do_write = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Inter-byte idle counter: only runs while a frame is open and no byte arrives.
  always_ff @(posedge clk_system) begin
    if (reset || !in_frame || rx_valid) tmo_cnt <= '0;
    else                                tmo_cnt <= tmo_cnt + TMO_ONE;
  end

  // Frame capture: address, length, running checksum and payload buffer.
  always_ff @(posedge clk_system) begin
    if (reset) begin
      addr_q    <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      cmt_idx_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) buffer[i] <= '0;
    end else begin
      case (state)
        S_ADDR: begin
          if (take) begin
            addr_q <= rx_data;
            sum_q  <= rx_data;
          end
        end
        S_LEN: begin
          if (take && !len_bad) begin
            len_q <= rx_data[CNT_W-1:0];
            sum_q <= sum_q + rx_data;
            idx_q <= '0;
          end
        end
        S_DATA: begin
          if (take) begin
            buffer[idx_q[BUF_AW-1:0]] <= rx_data;
            sum_q                     <= sum_q + rx_data;
            idx_q                     <= idx_q + CNT_ONE;
          end
        end
        S_CHK: begin
          cmt_idx_q <= '0;
        end
        S_COMMIT: begin
          if (do_write) cmt_idx_q <= cmt_idx_q + CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered RAM port and status pulses; wr_addr/wr_data hold between commits.
  always_ff @(posedge clk_system) begin
    if (reset) begin
      wr        <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      wr        <= do_write;
      busy      <= do_write;
      frame_ok  <= do_ok;
      frame_err <= do_err;
      if (do_write) begin
        wr_addr <= addr_q + 8'(cmt_idx_q);
        wr_data <= buffer[cmt_idx_q[BUF_AW-1:0]];
      end
      if (do_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule
